reaction_session_ctrl: RTL and testbench

Session scheduler for the reaction-time tester. It sits above the single-trial reaction FSM and sequences `NUM_TRIALS` back-to-back trials. It collects each trial's millisecond result or false-start error, and computes last, best and average times plus the error count. It also selects which of these the 7-segment driver shows during and after the session.

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/rt_div_seq.sv | 83 ++++++++
 rtl/reaction_session_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester session logic.
package reaction_pkg;

    localparam int TIME_W = 14;
    localparam logic [TIME_W-1:0] MS_MAX = 14'd9999;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RUN    = 3'd2,
        S_GAP    = 3'd3,
        S_CALC   = 3'd4,
        S_REVIEW = 3'd5
    } sess_state_t;

    localparam logic [1:0] DISP_LAST = 2'd0;
    localparam logic [1:0] DISP_BEST = 2'd1;
    localparam logic [1:0] DISP_AVG  = 2'd2;
    localparam logic [1:0] DISP_ERR  = 2'd3;

endpackage

// File: rtl/rt_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle after a load cycle.
// done_o pulses for one cycle once quotient_o holds the final result.
module rt_div_seq #(
    parameter int DVD_W = 18,
    parameter int DVS_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVD_W-1:0] quotient_o
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DVS_W:0]   shifted_s;
    logic             fits_s;

    assign shifted_s = {rem_q, quo_q[DVD_W-1]};
    assign fits_s    = (shifted_s >= {1'b0, dvs_q});

    // Load operands on start, otherwise perform one restoring step per cycle.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i && !busy_q) begin
            rem_d  = {DVS_W{1'b0}};
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = CNT_W'(DVD_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // The partial remainder stays below the divisor, so it fits DVS_W bits.
            rem_d = fits_s ? DVS_W'(shifted_s - {1'b0, dvs_q}) : shifted_s[DVS_W-1:0];
            quo_d = {quo_q[DVD_W-2:0], fits_s};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= {DVS_W{1'b0}};
            quo_q  <= {DVD_W{1'b0}};
            dvs_q  <= {DVS_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/reaction_session_ctrl.sv
// Session scheduler: runs NUM_TRIALS trials, accumulates statistics and
// selects what the 7-segment display shows. All outputs come from flops.
module reaction_session_ctrl
    import reaction_pkg::*;
#(
    parameter int NUM_TRIALS     = 5,
    parameter int TIME_W         = 14,
    parameter int MS_MAX         = 9999,
    parameter int GAP_CYCLES     = 50_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              session_start,
    input  logic              trial_done,
    input  logic              trial_error,
    input  logic [TIME_W-1:0] trial_ms,
    input  logic              show_next,
    output logic              trial_go,
    output logic [3:0]        trial_idx,
    output logic [TIME_W-1:0] disp_value,
    output logic [1:0]        disp_sel,
    output logic              session_busy,
    output logic              session_done
);
    localparam int SUM_W = TIME_W + 4;
    localparam logic [TIME_W-1:0] MS_SAT    = TIME_W'(MS_MAX);
    localparam logic [3:0]        LAST_IDX  = 4'(NUM_TRIALS);
    localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       CALC_LAST = 32'(SUM_W);

    sess_state_t       state_q, state_d;
    logic [31:0]       tmr_q, tmr_d;
    logic [3:0]        idx_q, idx_d;
    logic [TIME_W-1:0] last_q, last_d, best_q, best_d, avg_q, avg_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [3:0]        valid_q, valid_d, err_q, err_d;
    logic [1:0]        sel_q, sel_d;
    logic [TIME_W-1:0] disp_q, disp_d;
    logic              go_q, busy_q, done_q;
    logic [TIME_W-1:0] ms_sat_s, div_avg_s;
    logic              timeout_s, result_s, div_start_s, div_busy_s, div_done_s;
    logic [SUM_W-1:0]  div_quo_s;

    assign ms_sat_s  = (trial_ms > MS_SAT) ? MS_SAT : trial_ms;
    assign timeout_s = (tmr_q == TO_LAST);
    assign result_s  = trial_done || trial_error || timeout_s;
    assign div_avg_s = (div_quo_s[SUM_W-1:TIME_W] != 4'd0) ? MS_SAT : div_quo_s[TIME_W-1:0];

    rt_div_seq #(.DVD_W(SUM_W), .DVS_W(4)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (div_start_s),
        .dividend_i (sum_q),
        .divisor_i  (valid_q),
        .busy_o     (div_busy_s),
        .done_o     (div_done_s),
        .quotient_o (div_quo_s)
    );

    // Session sequencing and statistics accumulation.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q + 32'd1;
        idx_d       = idx_q;
        last_d      = last_q;
        best_d      = best_q;
        avg_d       = avg_q;
        sum_d       = sum_q;
        valid_d     = valid_q;
        err_d       = err_q;
        sel_d       = sel_q;
        div_start_s = 1'b0;
        case (state_q)
            S_IDLE, S_REVIEW: begin
                if (state_q == S_REVIEW && div_done_s) begin
                    avg_d = div_avg_s;
                end else begin
                    avg_d = avg_q;
                end
                if (session_start) begin
                    state_d = S_ARM;
                    idx_d   = 4'd0;
                    last_d  = {TIME_W{1'b0}};
                    best_d  = MS_SAT;
                    avg_d   = {TIME_W{1'b0}};
                    sum_d   = {SUM_W{1'b0}};
                    valid_d = 4'd0;
                    err_d   = 4'd0;
                    sel_d   = DISP_LAST;
                end else if (state_q == S_REVIEW && show_next) begin
                    sel_d = sel_q + 2'd1;
                end else begin
                    sel_d = sel_q;
                end
            end
            S_ARM: begin
                state_d = S_RUN;
                tmr_d   = 32'd0;
            end
            S_RUN: begin
                // An error pulse wins over a simultaneous valid result.
                if (trial_error || timeout_s) begin
                    err_d  = err_q + 4'd1;
                    last_d = MS_SAT;
                end else if (trial_done) begin
                    last_d  = ms_sat_s;
                    best_d  = (ms_sat_s < best_q) ? ms_sat_s : best_q;
                    sum_d   = sum_q + SUM_W'(ms_sat_s);
                    valid_d = valid_q + 4'd1;
                end else begin
                    last_d = last_q;
                end
                if (result_s) begin
                    idx_d   = idx_q + 4'd1;
                    tmr_d   = 32'd0;
                    state_d = ((idx_q + 4'd1) == LAST_IDX) ? S_CALC : S_GAP;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_CALC: begin
                // Fixed-length CALC; the divider result is captured as REVIEW starts.
                div_start_s = (tmr_q == 32'd0) && (valid_q != 4'd0) && !div_busy_s;
                if (valid_q == 4'd0) begin
                    avg_d  = MS_SAT;
                    best_d = MS_SAT;
                end else begin
                    avg_d = avg_q;
                end
                if (tmr_q == CALC_LAST) begin
                    state_d = S_REVIEW;
                    sel_d   = DISP_BEST;
                end else begin
                    state_d = S_CALC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Display mux driven from next-state values so the registered output lines up.
    always_comb begin
        case (sel_d)
            DISP_LAST: disp_d = last_d;
            DISP_BEST: disp_d = best_d;
            DISP_AVG:  disp_d = avg_d;
            DISP_ERR:  disp_d = {{(TIME_W-4){1'b0}}, err_d};
            default:   disp_d = last_d;
        endcase
    end

    // State, statistics and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= 32'd0;
            idx_q   <= 4'd0;
            last_q  <= {TIME_W{1'b0}};
            best_q  <= MS_SAT;
            avg_q   <= {TIME_W{1'b0}};
            sum_q   <= {SUM_W{1'b0}};
            valid_q <= 4'd0;
            err_q   <= 4'd0;
            sel_q   <= DISP_LAST;
            disp_q  <= {TIME_W{1'b0}};
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            best_q  <= best_d;
            avg_q   <= avg_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            disp_q  <= disp_d;
            go_q    <= (state_d == S_ARM);
            busy_q  <= (state_d != S_IDLE) && (state_d != S_REVIEW);
            done_q  <= (state_d == S_REVIEW);
        end
    end

    assign trial_go     = go_q;
    assign trial_idx    = idx_q;
    assign disp_value   = disp_q;
    assign disp_sel     = sel_q;
    assign session_busy = busy_q;
    assign session_done = done_q;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Directed scoreboard bench for reaction_session_ctrl (3 trials, short gap/timeout).
module tb_reaction_session_ctrl;

    localparam int NT  = 3;
    localparam int GAP = 4;
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        session_start, trial_done, trial_error, show_next;
    logic [13:0] trial_ms;
    logic        trial_go, session_busy, session_done;
    logic [3:0]  trial_idx;
    logic [13:0] disp_value;
    logic [1:0]  disp_sel;

    always #5 clk = ~clk;

    reaction_session_ctrl #(
        .NUM_TRIALS(NT), .TIME_W(14), .MS_MAX(9999),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .session_start(session_start),
        .trial_done(trial_done), .trial_error(trial_error), .trial_ms(trial_ms),
        .show_next(show_next), .trial_go(trial_go), .trial_idx(trial_idx),
        .disp_value(disp_value), .disp_sel(disp_sel),
        .session_busy(session_busy), .session_done(session_done)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   m_sum, m_valid, m_err, m_best, m_last, m_idx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, trial_go, trial_idx, disp_value, disp_sel, session_busy, session_done};
    endfunction

    task automatic start_session(input string tag);
        session_start = 1'b1;
        tick();
        session_start = 1'b0;
        m_sum = 0; m_valid = 0; m_err = 0; m_best = 9999; m_last = 0; m_idx = 0;
        push({tag, "_start_state"}, {9'd0, 1'b1, 4'd0, 14'd0, 2'd0, 1'b1, 1'b0});
        pop_check(outs());
    endtask

    task automatic wait_go(output int n);
        n = 0;
        while (trial_go !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // kind: 0 = valid result, 1 = false start, 2 = done and error together
    task automatic run_trial(input int kind, input int ms);
        int n;
        int el;
        wait_go(n);
        push("trial_go", 32'd1);
        pop_check({31'd0, trial_go});
        if (m_idx != 0) begin
            push("gap_len", GAP);
            pop_check(n);
        end
        tick();
        trial_done  = (kind != 1);
        trial_error = (kind != 0);
        trial_ms    = 14'(ms);
        if (kind != 0) begin
            m_err++;
            el = 9999;
        end else begin
            el = (ms > 9999) ? 9999 : ms;
            m_sum += el;
            m_valid++;
            if (el < m_best) m_best = el;
        end
        m_last = el;
        m_idx++;
        push("last", el);
        push("trial_idx", m_idx);
        tick();
        trial_done  = 1'b0;
        trial_error = 1'b0;
        pop_check({18'd0, disp_value});
        pop_check({28'd0, trial_idx});
    endtask

    task automatic finish_session(input string tag);
        int n;
        int avg;
        n = 0;
        while (session_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        push({tag, "_calc_len"}, 19);
        pop_check(n);
        avg = (m_valid == 0) ? 9999 : m_sum / m_valid;
        push({tag, "_review_best"}, {16'd0, 2'd1, 14'(m_best)});
        push({tag, "_review_flags"}, 32'd1);
        push({tag, "_sel_avg"},  {16'd0, 2'd2, 14'(avg)});
        push({tag, "_sel_err"},  {16'd0, 2'd3, 14'(m_err)});
        push({tag, "_sel_last"}, {16'd0, 2'd0, 14'(m_last)});
        push({tag, "_sel_best"}, {16'd0, 2'd1, 14'(m_best)});
        pop_check({16'd0, disp_sel, disp_value});
        pop_check({30'd0, session_busy, session_done});
        for (int k = 0; k < 4; k++) begin
            show_next = 1'b1;
            tick();
            show_next = 1'b0;
            pop_check({16'd0, disp_sel, disp_value});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; session_start = 1'b0; trial_done = 1'b0;
        trial_error = 1'b0; show_next = 1'b0; trial_ms = 14'd0;
        #12;
        push("reset_outs", 32'd0);
        pop_check(outs());
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        start_session("s1");
        run_trial(0, 250);
        run_trial(0, 300);
        run_trial(0, 200);
        finish_session("s1");

        start_session("s2");
        run_trial(0, 250);
        run_trial(1, 0);
        run_trial(0, 301);
        finish_session("s2");

        start_session("s3");
        run_trial(1, 0);
        run_trial(1, 0);
        run_trial(1, 0);
        finish_session("s3");

        start_session("s4");
        run_trial(0, 12000);
        run_trial(2, 777);
        run_trial(0, 100);
        finish_session("s4");

        // No response: timeout on the 10th RUN cycle; a start pulse mid-run is ignored.
        start_session("s5");
        n = 0;
        while (trial_idx == 4'd0 && n < 30) begin
            session_start = (n == 3);
            tick();
            session_start = 1'b0;
            n++;
        end
        m_err++; m_last = 9999; m_idx = 1;
        push("timeout_lat", 32'd11);
        push("timeout_last", 32'd9999);
        pop_check(n);
        pop_check({18'd0, disp_value});
        run_trial(0, 500);
        run_trial(0, 600);
        finish_session("s5");

        start_session("s6");
        run_trial(0, 123);
        #2;
        reset_n = 1'b0;
        #1;
        push("async_reset_outs", 32'd0);
        pop_check(outs());
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        push("idle_after_reset", 32'd0);
        pop_check(outs());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
